// File: rtl/vga_sync_gen.sv
// 640x480 @ 60 Hz VGA timing: pixel-tick divider, h/v counters, registered syncs and end-of-frame pulse.
// The syncs and frame_tick are computed from the next-state counters so they line up with the x/y they describe.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             tick_next;

    // p_tick decodes straight from the divider register, so it cannot glitch.
    assign p_tick   = (div_cnt == DIV_LAST);
    assign video_on = (x < H_VIS) && (y < V_VIS);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        x_next   = x;
        y_next   = y;
        if (p_tick) begin
            if (x == H_LAST) begin
                x_next = '0;
                y_next = (y == V_LAST) ? '0 : y + 1'b1;
            end else begin
                x_next = x + 1'b1;
            end
        end
    end

    assign tick_next = (div_next == DIV_LAST);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt    <= '0;
            x          <= '0;
            y          <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= div_next;
            x          <= x_next;
            y          <= y_next;
            hsync      <= !((x_next >= HS_START) && (x_next <= HS_END));
            vsync      <= !((y_next >= VS_START) && (y_next <= VS_END));
            frame_tick <= tick_next && (x_next == H_LAST) && (y_next == V_LAST);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: default timing, a shrunken frame for frame-level events, and CLK_DIV=2.
// Expected samples are queued with (reset epoch, clocks since reset) keys; the monitor compares them as they come due.
module tb_vga_sync_gen;

    typedef struct {
        int         dut;
        int         epoch;
        int         n;
        int         ex;
        int         ey;
        logic [4:0] flags;   // {hsync, vsync, video_on, p_tick, frame_tick}
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic [9:0] x_0, y_0, x_1, y_1, x_2, y_2;
    logic hs_0, vs_0, von_0, pt_0, ft_0;
    logic hs_1, vs_1, von_1, pt_1, ft_1;
    logic hs_2, vs_2, von_2, pt_2, ft_2;

    exp_t sb[$];
    int   epoch = 0;
    int   n     = 0;
    logic in_rst = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int c_hs0 = 0, c_pt0 = 0, c_von0 = 0;
    int c_ft1 = 0, c_y7_1 = 0, c_vs1 = 0;
    int c_hs2 = 0, c_pt2 = 0;
    int range_err = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk(clk), .reset(reset), .hsync(hs_0), .vsync(vs_0), .video_on(von_0),
        .p_tick(pt_0), .x(x_0), .y(y_0), .frame_tick(ft_0)
    );

    // 15 x 10 pixel frame: hsync on x=10..12, vsync on y=7..8, visible 8 x 6.
    vga_sync_gen #(
        .CLK_DIV(4), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .clk(clk), .reset(reset), .hsync(hs_1), .vsync(vs_1), .video_on(von_1),
        .p_tick(pt_1), .x(x_1), .y(y_1), .frame_tick(ft_1)
    );

    vga_sync_gen #(.CLK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .hsync(hs_2), .vsync(vs_2), .video_on(von_2),
        .p_tick(pt_2), .x(x_2), .y(y_2), .frame_tick(ft_2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic expect_at(input int d, input int ep, input int cyc,
                             input int ex, input int ey, input logic [4:0] fl);
        exp_t e;
        e.dut = d; e.epoch = ep; e.n = cyc; e.ex = ex; e.ey = ey; e.flags = fl;
        sb.push_back(e);
    endtask

    function automatic logic [24:0] observe(input int d);
        case (d)
            0:       return {x_0, y_0, hs_0, vs_0, von_0, pt_0, ft_0};
            1:       return {x_1, y_1, hs_1, vs_1, von_1, pt_1, ft_1};
            default: return {x_2, y_2, hs_2, vs_2, von_2, pt_2, ft_2};
        endcase
    endfunction

    // Each reset assertion opens a new epoch; n counts edges since reset was last sampled low.
    always @(posedge clk) begin
        if (!reset) begin
            if (!in_rst) epoch <= epoch + 1;
            in_rst <= 1'b1;
            n      <= 0;
        end else begin
            in_rst <= 1'b0;
            n      <= n + 1;
        end
    end

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].epoch < epoch || (sb[i].epoch == epoch && sb[i].n < n)) begin
                check($sformatf("d%0d e%0d n%0d missed sample (clk now)", sb[i].dut, sb[i].epoch, sb[i].n),
                      n, sb[i].n);
                sb.delete(i);
            end else if (sb[i].epoch == epoch && sb[i].n == n) begin
                logic [24:0] o;
                string       tag;
                o   = observe(sb[i].dut);
                tag = $sformatf("d%0d e%0d n%0d", sb[i].dut, sb[i].epoch, sb[i].n);
                check({tag, " x"}, int'(o[24:15]), sb[i].ex);
                check({tag, " y"}, int'(o[14:5]), sb[i].ey);
                check({tag, " {hs,vs,von,pt,ft}"}, int'(o[4:0]), int'(sb[i].flags));
                sb.delete(i);
            end
        end

        if (epoch >= 1) begin
            if (x_0 > 10'd799 || y_0 > 10'd524 || x_1 > 10'd14 || y_1 > 10'd9 ||
                x_2 > 10'd799 || y_2 > 10'd524)
                range_err++;
        end

        if (epoch == 1 && n >= 1) begin
            if (n < 3200) begin
                if (!hs_0) c_hs0++;
                if (pt_0) c_pt0++;
                if (!von_0) c_von0++;
            end
            if (n < 3000) begin
                if (ft_1) c_ft1++;
                if (pt_1 && x_1 == 10'd0 && y_1 == 10'd7) c_y7_1++;
                if (!vs_1) c_vs1++;
            end
            if (n < 1600) begin
                if (!hs_2) c_hs2++;
                if (pt_2) c_pt2++;
            end
        end
    end

    initial begin
        reset = 1'b0;

        // Reset state on all three instances.
        for (int d = 0; d < 3; d++) expect_at(d, 1, 0, 0, 0, 5'b11100);

        // Default timing, CLK_DIV=4: divider start, hsync window, line wrap.
        expect_at(0, 1, 1,    0,   0, 5'b11100);
        expect_at(0, 1, 3,    0,   0, 5'b11110);
        expect_at(0, 1, 4,    1,   0, 5'b11100);
        expect_at(0, 1, 7,    1,   0, 5'b11110);
        expect_at(0, 1, 2556, 639, 0, 5'b11100);
        expect_at(0, 1, 2560, 640, 0, 5'b11000);
        expect_at(0, 1, 2623, 655, 0, 5'b11010);
        expect_at(0, 1, 2624, 656, 0, 5'b01000);
        expect_at(0, 1, 3007, 751, 0, 5'b01010);
        expect_at(0, 1, 3008, 752, 0, 5'b11000);
        expect_at(0, 1, 3199, 799, 0, 5'b11010);
        expect_at(0, 1, 3200, 0,   1, 5'b11100);
        expect_at(0, 1, 3204, 1,   1, 5'b11100);

        // Shrunken frame: syncs, vsync edges, frame wrap, state just before the mid-frame reset.
        expect_at(1, 1, 3,    0,  0, 5'b11110);
        expect_at(1, 1, 28,   7,  0, 5'b11100);
        expect_at(1, 1, 32,   8,  0, 5'b11000);
        expect_at(1, 1, 40,   10, 0, 5'b01000);
        expect_at(1, 1, 52,   13, 0, 5'b11000);
        expect_at(1, 1, 60,   0,  1, 5'b11100);
        expect_at(1, 1, 420,  0,  7, 5'b10000);
        expect_at(1, 1, 539,  14, 8, 5'b10010);
        expect_at(1, 1, 540,  0,  9, 5'b11000);
        expect_at(1, 1, 598,  14, 9, 5'b11000);
        expect_at(1, 1, 599,  14, 9, 5'b11011);
        expect_at(1, 1, 600,  0,  0, 5'b11100);
        expect_at(1, 1, 3468, 12, 7, 5'b00000);

        // CLK_DIV=2: tick every other clock, same sync pixels.
        expect_at(2, 1, 1,    0,   0, 5'b11110);
        expect_at(2, 1, 2,    1,   0, 5'b11100);
        expect_at(2, 1, 1311, 655, 0, 5'b11010);
        expect_at(2, 1, 1312, 656, 0, 5'b01000);
        expect_at(2, 1, 1599, 799, 0, 5'b11010);
        expect_at(2, 1, 1600, 0,   1, 5'b11100);

        // One-clock reset while the small frame sits inside both sync pulses, then normal restart.
        for (int d = 0; d < 3; d++) expect_at(d, 2, 0, 0, 0, 5'b11100);
        expect_at(1, 2, 3,   0, 0, 5'b11110);
        expect_at(1, 2, 4,   1, 0, 5'b11100);
        expect_at(1, 2, 420, 0, 7, 5'b10000);

        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3468) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (430) @(posedge clk);
        @(negedge clk);
        #1;

        check("line hsync-low clks",       c_hs0,  384);
        check("line p_tick count",         c_pt0,  800);
        check("line video_off clks",       c_von0, 640);
        check("small frame_tick pulses",   c_ft1,  5);
        check("small (x=0,y=V_DISP+1) hits", c_y7_1, 5);
        check("small vsync-low clks",      c_vs1,  600);
        check("div2 hsync-low clks",       c_hs2,  192);
        check("div2 p_tick count",         c_pt2,  800);
        check("counter range violations",  range_err, 0);
        check("scoreboard left over",      sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
